// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sequencer for two requesters sharing one registered ALU
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_inA,
  input  logic [WIDTH-1:0] req0_inB,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_inA,
  input  logic [WIDTH-1:0] req1_inB,
  output logic [WIDTH-1:0] alu_inA,
  output logic [WIDTH-1:0] alu_inB,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_flag,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_out,
  output logic             resp_flag,
  input  logic             resp_ready,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nxt;
  logic last_grant, grant, accept;
  assign busy = state != IDLE;
  always_comb begin
    grant      = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    req0_ready = (state == IDLE) & req0_valid & ~grant;
    req1_ready = (state == IDLE) & req1_valid & grant;
    accept     = req0_ready | req1_ready;
    state_nxt  = state == IDLE ? (accept ? EXEC : IDLE) :
                 state == EXEC ? RESP :
                 resp_ready ? IDLE : RESP;
  end
  // last_grant resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      alu_inA    <= '0;
      alu_inB    <= '0;
      alu_op     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_out   <= '0;
      resp_flag  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_inA    <= grant ? req1_inA : req0_inA;
        alu_inB    <= grant ? req1_inB : req0_inB;
        alu_op     <= grant ? req1_op : req0_op;
        resp_id    <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        resp_out   <= alu_out;
        resp_flag  <= alu_flag;
        resp_valid <= 1'b1;
      end
      if (state == RESP && resp_ready) resp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vectors against a behavioural ALU attached to the shared datapath
module tb_alu_share_arbiter;
  logic        clk = 0, rst = 1;
  logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [1:0]  req0_op = 0, req1_op = 0, alu_op;
  logic [31:0] req0_inA = 0, req0_inB = 0, req1_inA = 0, req1_inB = 0;
  logic [31:0] alu_inA, alu_inB, alu_out, resp_out;
  logic        alu_flag, resp_valid, resp_id, resp_flag, resp_ready = 0, busy;
  int n_vec = 0, n_err = 0;

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_inA(req0_inA), .req0_inB(req0_inB),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_inA(req1_inA), .req1_inB(req1_inB),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flag(alu_flag),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_out(resp_out),
    .resp_flag(resp_flag), .resp_ready(resp_ready), .busy(busy)
  );

  assign alu_out  = alu_op == 2'd0 ? alu_inA ^ alu_inB :
                    alu_op == 2'd1 ? alu_inA & alu_inB :
                    alu_op == 2'd2 ? alu_inA | alu_inB : alu_inA + alu_inB;
  assign alu_flag = alu_out == 32'd0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // single-requester op from IDLE with resp_ready high; returns #1 after edge in IDLE
  task automatic single(input logic id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_out, input logic exp_flag);
    resp_ready = 1;
    if (id) begin req1_valid = 1; req1_op = op; req1_inA = a; req1_inB = b; end
    else    begin req0_valid = 1; req0_op = op; req0_inA = a; req0_inB = b; end
    #3;
    chk("single_ready", {30'd0, req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
    chk("single_idle_busy", busy, 0);
    step();
    req0_valid = 0; req1_valid = 0;
    chk("single_exec_busy", busy, 1);
    chk("single_exec_nresp", resp_valid, 0);
    chk("single_alu_inA", alu_inA, a);
    chk("single_alu_op", alu_op, op);
    step();
    chk("single_resp_valid", resp_valid, 1);
    chk("single_resp_out", resp_out, exp_out);
    chk("single_resp_flag", resp_flag, exp_flag);
    chk("single_resp_id", resp_id, id);
    step();
    chk("single_resp_one_cycle", resp_valid, 0);
    chk("single_back_idle", busy, 0);
  endtask

  initial begin
    step();
    step();
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_inA", alu_inA, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_resp_out", resp_out, 0);
    rst = 0;
    step();

    single(0, 2'd0, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 0);
    single(1, 2'd0, 32'h12345678, 32'h12345678, 32'h0, 1);
    single(0, 2'd3, 32'hFFFFFFFF, 32'h1, 32'h0, 1);
    single(1, 2'd1, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h05050505, 0);
    single(0, 2'd2, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAFAFAFAF, 0);

    // tie and alternation straight from reset
    rst = 1; #2; rst = 0;
    step();
    resp_ready = 1;
    req0_valid = 1; req0_op = 2'd0; req0_inA = 32'h000000FF; req0_inB = 32'h0000000F;
    req1_valid = 1; req1_op = 2'd3; req1_inA = 32'h00000010; req1_inB = 32'h00000020;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("alt_ready", {30'd0, req1_ready, req0_ready}, i % 2 ? 32'd2 : 32'd1);
      step();
      chk("alt_exec_ready", {30'd0, req1_ready, req0_ready}, 0);
      step();
      chk("alt_resp_id", resp_id, i % 2);
      chk("alt_resp_out", resp_out, i % 2 ? 32'h00000030 : 32'h000000F0);
      step();
    end

    // backpressure: last grant was 1, so requester 0 goes next while 1 waits
    resp_ready = 0;
    #3;
    chk("bp_accept0", req0_ready, 1);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_id", resp_id, 0);
      chk("bp_resp_out", resp_out, 32'h000000F0);
      chk("bp_busy", busy, 1);
      chk("bp_no_ready", {30'd0, req1_ready, req0_ready}, 0);
      chk("bp_alu_inA", alu_inA, 32'h000000FF);
      step();
    end
    resp_ready = 1;
    step();
    chk("bp_release_idle", busy, 0);
    chk("bp_release_nresp", resp_valid, 0);
    chk("bp_waiting_ready", {30'd0, req1_ready, req0_ready}, 2);
    step();
    req0_valid = 0; req1_valid = 0;
    chk("bp_waiting_id", resp_id, 1);
    step();
    chk("bp_waiting_out", resp_out, 32'h00000030);
    step();

    // reset during EXEC after a requester-0 grant
    req0_valid = 1; req0_op = 2'd3; req0_inA = 32'h11111111; req0_inB = 32'h22222222;
    step();
    req0_valid = 0;
    chk("rexec_in_exec", busy, 1);
    #2 rst = 1;
    #1;
    chk("rexec_busy", busy, 0);
    chk("rexec_alu_inA", alu_inA, 0);
    chk("rexec_alu_op", alu_op, 0);
    #3 rst = 0;
    step();
    chk("rexec_idle", busy, 0);
    chk("rexec_resp_valid", resp_valid, 0);
    req0_valid = 1; req1_valid = 1;
    req0_op = 2'd2; req0_inA = 32'h0; req0_inB = 32'h0;
    #3;
    chk("rexec_tie_to_0", {30'd0, req1_ready, req0_ready}, 1);
    step();
    req0_valid = 0;
    step();
    chk("rexec_zero_resp", {30'd0, resp_flag, resp_valid}, 3);
    step();

    // requester 1 still valid: take it, then reset while holding in RESP
    resp_ready = 0;
    #3;
    chk("rresp_accept1", req1_ready, 1);
    step();
    req1_valid = 0;
    step();
    chk("rresp_in_resp", resp_valid, 1);
    chk("rresp_id_before", resp_id, 1);
    #2 rst = 1;
    #1;
    chk("rresp_valid", resp_valid, 0);
    chk("rresp_id", resp_id, 0);
    chk("rresp_out", resp_out, 0);
    chk("rresp_busy", busy, 0);
    #3 rst = 0;
    step();
    req0_valid = 1; req1_valid = 1;
    #3;
    chk("rresp_tie_to_0", {30'd0, req1_ready, req0_ready}, 1);
    step();
    req0_valid = 0; req1_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
